ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter TIMEOUT_CYC, default 40000, clk cycles of ps2_clk inactivity mid-frame before the frame is aborted.
REQ-002 clk  input  1  system clock, single clock domain.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 ps2_clk  input  1  PS/2 device clock, asynchronous to clk.
REQ-005 ps2_data  input  1  PS/2 device data, asynchronous to clk.
REQ-006 key  output  4  held key state: [0] up, [1] down, [2] left, [3] right; 1 = pressed.
REQ-007 code  output  8  last correctly received scan byte.
REQ-008 code_valid  output  1  one-cycle pulse, code updated this cycle.
REQ-009 frame_err  output  1  one-cycle pulse, parity or stop-bit error.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-FF synchronizer; a ps2_clk falling edge is the synchronized value changing 1->0, detected with one further register stage.
REQ-011 Frame FSM states IDLE, DATA, PARITY, STOP; all transitions occur only on a detected falling edge, except the timeout in REQ-016.
REQ-012 IDLE: sampled data 0 -> DATA with bit counter 0; sampled data 1 -> stay IDLE, no error.
REQ-013 DATA: shift the sampled bit in LSB-first; after the 8th bit -> PARITY.
REQ-014 PARITY: latch the bit; odd parity over the 8 data bits plus the parity bit is required -> STOP.
REQ-015 STOP: stop bit 1 and parity good -> code <= byte, code_valid = 1 on the next clk cycle; otherwise frame_err = 1 and code is unchanged; in both cases -> IDLE.
REQ-016 Outside IDLE, a counter runs TIMEOUT_CYC cycles from the last falling edge; on expiry -> IDLE, partial byte discarded, no pulse, ext/brk flags cleared.
REQ-017 Decoder latency: key updates in the same cycle code_valid is asserted.
REQ-018 Byte 0xE0 sets ext; byte 0xF0 sets brk; neither changes key.
REQ-019 Any other byte with ext=1: 0x75->bit0, 0x72->bit1, 0x6B->bit2, 0x74->bit3; brk=0 sets the bit, brk=1 clears it; ext and brk are then cleared.
REQ-020 Any other byte with ext=0, or an unmapped extended byte: key unchanged, ext and brk cleared.
REQ-021 A break for a key not pressed leaves key unchanged; repeated make codes (typematic) keep the bit at 1.
REQ-022 Several bits of key may be 1 at once; bits are independent.
REQ-023 frame_err SHALL clear ext and brk so a corrupted prefix never pairs with a later code.

Reset
REQ-024 On rst low, asynchronously: FSM IDLE, shift register and bit counter 0, timeout counter 0, ext=brk=0, key=4'b0000, code=8'h00, code_valid=0, frame_err=0, synchronizers to 1.
REQ-025 Reset asserted mid-frame discards the frame; the first frame after release is accepted only if its start bit begins after release.

Structure
REQ-026 Package ps2_pkg holds the frame-state enum, the scan-code constants (0xE0, 0xF0, 0x75, 0x72, 0x6B, 0x74) and the key bit indices.
REQ-027 Sub-module ps2_rx_frame implements REQ-010 to REQ-016 (byte + valid + err); ps2_key_decoder instantiates it and implements REQ-017 to REQ-023.

Verification
REQ-028 Frames E0,75 (all parity good, 12.5 kHz ps2_clk) -> key=4'b0001, code_valid pulses twice, code=0x75.
REQ-029 With up held, send E0,F0,75 -> key=4'b0000; then E0,6B followed by E0,74 -> key=4'b1100.
REQ-030 Byte 0x1C with wrong parity -> frame_err one cycle, code_valid 0, code unchanged; a following good E0,72 -> key[1]=1.
REQ-031 ps2_clk stopped after 4 data bits for more than TIMEOUT_CYC cycles, then a clean frame 0x75 with no E0 prefix -> no pulses during the timeout, key unchanged after 0x75.
REQ-032 rst pulsed low mid-frame with key=4'b1111 -> all outputs 0 immediately; the remainder of the aborted frame produces no code_valid.
REQ-033 Break for an unpressed key (E0,F0,72 with key=0) -> key stays 4'b0000, no frame_err.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 arrow-key decoder: frame states, scan codes
// and key bit positions.
package ps2_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

    // One-hot key mask for an extended scan code; zero when unmapped.
    function automatic logic [3:0] key_mask(input logic [7:0] sc);
        logic [3:0] m;
        m = 4'b0000;
        case (sc)
            SC_UP:    m[KEY_UP]    = 1'b1;
            SC_DOWN:  m[KEY_DOWN]  = 1'b1;
            SC_LEFT:  m[KEY_LEFT]  = 1'b1;
            SC_RIGHT: m[KEY_RIGHT] = 1'b1;
            default:  m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizes the device lines, deframes 11-bit frames
// on ps2_clk falling edges and aborts a stalled frame after a timeout.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 40000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       err_o,
    output logic       abort_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic          clk_s1_q, clk_s2_q, clk_s3_q;
    logic          data_s1_q, data_s2_q;
    logic [1:0]    state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          fall;

    // clk_s3_q is the edge-detect stage behind the two synchronizer flops.
    assign fall   = clk_s3_q & ~clk_s2_q;
    assign byte_o = shift_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        tmo_d   = tmo_q;
        valid_o = 1'b0;
        err_o   = 1'b0;
        abort_o = 1'b0;

        if (state_q == ST_IDLE || fall) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            abort_o = 1'b1;
            state_d = ST_IDLE;
            shift_d = 8'h00;
            cnt_d   = 3'd0;
            tmo_d   = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!data_s2_q) begin
                        state_d = ST_DATA;
                        shift_d = 8'h00;
                        cnt_d   = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d = {data_s2_q, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = data_s2_q;
                    state_d = ST_STOP;
                end
                default: begin
                    if (data_s2_q && odd_parity_ok(shift_q, par_q)) valid_o = 1'b1;
                    else                                             err_o   = 1'b1;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            clk_s3_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
            state_q   <= ST_IDLE;
            shift_q   <= 8'h00;
            cnt_q     <= 3'd0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            clk_s1_q  <= ps2_clk_i;
            clk_s2_q  <= clk_s1_q;
            clk_s3_q  <= clk_s2_q;
            data_s1_q <= ps2_data_i;
            data_s2_q <= data_s1_q;
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 arrow-key decoder: tracks E0/F0 prefixes and holds the up/down/left/right
// pressed state from received scan bytes.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 40000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] key,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_err, rx_abort;
    logic [3:0] key_q, key_d, mask;
    logic [7:0] code_q, code_d;
    logic       cv_q, cv_d, fe_q, fe_d;
    logic       ext_q, ext_d, brk_q, brk_d;

    ps2_rx_frame #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk_i     (clk),
        .rst_ni    (rst),
        .ps2_clk_i (ps2_clk),
        .ps2_data_i(ps2_data),
        .byte_o    (rx_byte),
        .valid_o   (rx_valid),
        .err_o     (rx_err),
        .abort_o   (rx_abort)
    );

    assign mask = key_mask(rx_byte);

    always_comb begin
        key_d  = key_q;
        code_d = code_q;
        ext_d  = ext_q;
        brk_d  = brk_q;
        cv_d   = 1'b0;
        fe_d   = rx_err;
        // A damaged or stalled frame must not leave a prefix armed for the next code.
        if (rx_err || rx_abort) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
        if (rx_valid) begin
            cv_d   = 1'b1;
            code_d = rx_byte;
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                if (ext_q) key_d = brk_q ? (key_q & ~mask) : (key_q | mask);
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q  <= 4'b0000;
            code_q <= 8'h00;
            cv_q   <= 1'b0;
            fe_q   <= 1'b0;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
        end else begin
            key_q  <= key_d;
            code_q <= code_d;
            cv_q   <= cv_d;
            fe_q   <= fe_d;
            ext_q  <= ext_d;
            brk_q  <= brk_d;
        end
    end

    assign key        = key_q;
    assign code       = code_q;
    assign code_valid = cv_q;
    assign frame_err  = fe_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames, pulse counters
// and immediate-assertion checks against hand-computed values.
module tb_ps2_key_decoder;

    localparam int TMO  = 200;
    localparam int HALF = 20;
    localparam int GAP  = 60;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] key;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;

    int tests;
    int failed;
    int cv_cnt;
    int fe_cnt;
    int cv0;
    int fe0;

    ps2_key_decoder #(
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key       (key),
        .code      (code),
        .code_valid(code_valid),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cv_cnt = 0;
        fe_cnt = 0;
    end

    // Counts clock cycles each pulse is high; a stuck pulse inflates the count.
    always @(posedge clk) begin
        if (code_valid === 1'b1) cv_cnt <= cv_cnt + 1;
        if (frame_err === 1'b1)  fe_cnt <= fe_cnt + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        wait_clk(HALF);
        ps2_clk = 1'b0;
        wait_clk(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic good_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(good_par ? ~^b : ^b);
        ps2_bit(1'b1);
        wait_clk(GAP);
    endtask

    initial begin
        logic [7:0] b;
        tests    = 0;
        failed   = 0;
        rst      = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clk(5);
        chk("reset_key", 32'(key), 32'h0);
        chk("reset_code", 32'(code), 32'h0);
        chk("reset_cv", 32'(code_valid), 32'h0);
        chk("reset_fe", 32'(frame_err), 32'h0);
        rst = 1'b1;
        wait_clk(10);

        // Extended up press.
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_frame(8'hE0, 1'b1);
        send_frame(8'h75, 1'b1);
        chk("up_key", 32'(key), 32'h1);
        chk("up_code", 32'(code), 32'h75);
        chk("up_cv_pulses", 32'(cv_cnt - cv0), 32'd2);
        chk("up_fe_pulses", 32'(fe_cnt - fe0), 32'd0);

        // Release up, then press left and right.
        send_frame(8'hE0, 1'b1);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h75, 1'b1);
        chk("up_release_key", 32'(key), 32'h0);
        send_frame(8'hE0, 1'b1);
        send_frame(8'h6B, 1'b1);
        send_frame(8'hE0, 1'b1);
        send_frame(8'h74, 1'b1);
        chk("left_right_key", 32'(key), 32'hC);
        chk("left_right_code", 32'(code), 32'h74);

        // Bad parity frame.
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_frame(8'h1C, 1'b0);
        chk("parity_fe_pulses", 32'(fe_cnt - fe0), 32'd1);
        chk("parity_cv_pulses", 32'(cv_cnt - cv0), 32'd0);
        chk("parity_code_kept", 32'(code), 32'h74);
        chk("parity_key_kept", 32'(key), 32'hC);
        send_frame(8'hE0, 1'b1);
        send_frame(8'h72, 1'b1);
        chk("down_after_err_key", 32'(key), 32'hE);

        // A frame error between the prefixes and 0x6B must disarm the break.
        send_frame(8'hE0, 1'b1);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h1C, 1'b0);
        send_frame(8'h6B, 1'b1);
        chk("err_clears_prefix_key", 32'(key), 32'hE);
        chk("err_clears_prefix_code", 32'(code), 32'h6B);

        // Stall mid-frame after an E0 prefix.
        send_frame(8'hE0, 1'b1);
        cv0 = cv_cnt; fe0 = fe_cnt;
        b = 8'h75;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(b[i]);
        wait_clk(TMO + 50);
        chk("timeout_cv_pulses", 32'(cv_cnt - cv0), 32'd0);
        chk("timeout_fe_pulses", 32'(fe_cnt - fe0), 32'd0);
        send_frame(8'h75, 1'b1);
        chk("timeout_clears_ext_key", 32'(key), 32'hE);
        chk("timeout_then_code", 32'(code), 32'h75);

        send_frame(8'hE0, 1'b1);
        send_frame(8'h75, 1'b1);
        chk("all_keys", 32'(key), 32'hF);

        // Reset in the middle of a frame.
        cv0 = cv_cnt; fe0 = fe_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(b[i]);
        @(negedge clk);
        #3 rst = 1'b0;
        #1;
        chk("midrst_key", 32'(key), 32'h0);
        chk("midrst_code", 32'(code), 32'h0);
        chk("midrst_cv", 32'(code_valid), 32'h0);
        chk("midrst_fe", 32'(frame_err), 32'h0);
        wait_clk(5);
        rst = 1'b1;
        for (int i = 3; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b);
        ps2_bit(1'b1);
        wait_clk(TMO + 50);
        chk("midrst_tail_cv_pulses", 32'(cv_cnt - cv0), 32'd0);
        chk("midrst_tail_key", 32'(key), 32'h0);

        // Break for a key that is not pressed.
        cv0 = cv_cnt; fe0 = fe_cnt;
        send_frame(8'hE0, 1'b1);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h72, 1'b1);
        chk("unpressed_break_key", 32'(key), 32'h0);
        chk("unpressed_break_fe", 32'(fe_cnt - fe0), 32'd0);
        chk("unpressed_break_cv", 32'(cv_cnt - cv0), 32'd3);
        chk("unpressed_break_code", 32'(code), 32'h72);

        // Typematic repeat, then an unextended byte.
        send_frame(8'hE0, 1'b1);
        send_frame(8'h75, 1'b1);
        send_frame(8'hE0, 1'b1);
        send_frame(8'h75, 1'b1);
        chk("typematic_key", 32'(key), 32'h1);
        send_frame(8'h1C, 1'b1);
        chk("plain_byte_key", 32'(key), 32'h1);
        chk("plain_byte_code", 32'(code), 32'h1C);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
